// File: rtl/program_loader.sv
// Purpose: loads a program image from a valid/ready beat stream into a memory write port, optionally zero-filling all cells first.
// Latency: a beat accepted in cycle N is written in cycle N+1; each zero-fill write appears one cycle after its CLEAR cycle.
// Backpressure: in_ready is high only in LOAD; no stalls inside LOAD; beats offered outside LOAD wait until in_ready.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, clear_first    session start (IDLE/DONE only) and zero-fill select
//   in_valid/in_data/in_last/in_ready   upstream beat handshake
//   mem_write_address/data/enable       registered memory write port
//   busy, done, overflow, word_count    session status
module program_loader #(
    parameter int CELL_COUNT = 256,
    parameter int LINE_WIDTH = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear_first,
    input  logic                  in_valid,
    input  logic [LINE_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [LINE_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CELL_COUNT - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  overflow_q, overflow_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;

    logic accept;
    logic at_last_cell;

    assign accept       = in_valid & in_ready_q;
    assign at_last_cell = (addr_q == LAST_ADDR);

    // State and datapath registers. Reset clears mem_we_q, so any write
    // that was about to be issued is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = clear_first ? ST_CLEAR : ST_LOAD;
                end
            end
            ST_CLEAR: begin
                if (at_last_cell) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Either the program ends or memory is full; the counter never wraps.
                if (accept && (in_last || at_last_cell)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: counter, word count, overflow and the write port.
    always_comb begin
        addr_d       = addr_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        // in_ready is registered so it is high exactly while state_q is LOAD.
        in_ready_d   = (state_d == ST_LOAD);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d       = '0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            ST_CLEAR: begin
                mem_we_d   = 1'b1;
                mem_addr_d = addr_q;
                mem_data_d = '0;
                addr_d     = at_last_cell ? '0 : addr_q + 1'b1;
            end
            ST_LOAD: begin
                if (accept) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = addr_q;
                    mem_data_d   = in_data;
                    word_count_d = word_count_q + 1'b1;
                    if (at_last_cell) begin
                        // Hold the counter at the top cell; flag overflow if the
                        // program was not complete.
                        overflow_d = ~in_last;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output decode.
    always_comb begin
        busy              = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
        done              = (state_q == ST_DONE);
        in_ready          = in_ready_q;
        overflow          = overflow_q;
        word_count        = word_count_q;
        mem_write_enable  = mem_we_q;
        mem_write_address = mem_addr_q;
        mem_write_data    = mem_data_q;
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear_first;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [7:0] mem_write_address;
    logic [3:0] mem_write_data;
    logic       mem_write_enable;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [8:0] word_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] wr_addr[$];
    logic [3:0] wr_data[$];

    program_loader #(
        .CELL_COUNT(256),
        .LINE_WIDTH(4),
        .ADDR_WIDTH(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .clear_first       (clear_first),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_enable  (mem_write_enable),
        .busy              (busy),
        .done              (done),
        .overflow          (overflow),
        .word_count        (word_count)
    );

    always #5 clk = ~clk;

    // Log every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) begin
            wr_addr.push_back(mem_write_address);
            wr_data.push_back(mem_write_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        start       = 1'b0;
        clear_first = 1'b0;
        in_valid    = 1'b0;
        in_data     = 4'h0;
        in_last     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
        checks++;
        if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", mem_write_enable); end
        checks++;
        if ({busy, done, overflow} !== 3'b000) begin failures++; $display("FAIL reset_status got=%0h exp=0", {busy, done, overflow}); end
        checks++;
        if ({word_count, mem_write_address, mem_write_data} !== 21'h0) begin
            failures++; $display("FAIL reset_data got wc=%0h addr=%0h data=%0h exp=0", word_count, mem_write_address, mem_write_data);
        end
    endtask

    task automatic test_plain_load();
        do_reset();
        start = 1'b1; clear_first = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b11) begin failures++; $display("FAIL plain_enter_load got=%0b exp=11", {busy, in_ready}); end
        clear_log();
        in_valid = 1'b1; in_data = 4'h3; in_last = 1'b0;
        tick();
        checks++;
        if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b1, 8'd0, 4'h3}) begin
            failures++; $display("FAIL plain_w0 got we=%0h addr=%0h data=%0h exp 1/0/3", mem_write_enable, mem_write_address, mem_write_data);
        end
        in_data = 4'h7;
        tick();
        checks++;
        if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b1, 8'd1, 4'h7}) begin
            failures++; $display("FAIL plain_w1 got we=%0h addr=%0h data=%0h exp 1/1/7", mem_write_enable, mem_write_address, mem_write_data);
        end
        in_data = 4'hA; in_last = 1'b1;
        tick();
        checks++;
        if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b1, 8'd2, 4'hA}) begin
            failures++; $display("FAIL plain_w2 got we=%0h addr=%0h data=%0h exp 1/2/a", mem_write_enable, mem_write_address, mem_write_data);
        end
        checks++;
        if ({done, in_ready, busy} !== 3'b100) begin failures++; $display("FAIL plain_done_state got=%0b exp=100", {done, in_ready, busy}); end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        checks++;
        if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b0, 8'd2, 4'hA}) begin
            failures++; $display("FAIL plain_hold got we=%0h addr=%0h data=%0h exp 0/2/a", mem_write_enable, mem_write_address, mem_write_data);
        end
        checks++;
        if ({done, overflow, word_count} !== {1'b1, 1'b0, 9'd3}) begin
            failures++; $display("FAIL plain_status got done=%0h ovf=%0h wc=%0d exp 1/0/3", done, overflow, word_count);
        end
        checks++;
        if (wr_addr.size() != 3) begin failures++; $display("FAIL plain_write_count got=%0d exp=3", wr_addr.size()); end
    endtask

    task automatic test_clear_load();
        int bad;
        do_reset();
        start = 1'b1; clear_first = 1'b1;
        tick();
        start = 1'b0; clear_first = 1'b0;
        checks++;
        if ({busy, in_ready, mem_write_enable} !== 3'b100) begin
            failures++; $display("FAIL clear_enter got busy/rdy/we=%0b exp=100", {busy, in_ready, mem_write_enable});
        end
        clear_log();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (mem_write_enable !== 1'b1 || mem_write_address !== 8'(i) || mem_write_data !== 4'h0) bad++;
            if (i < 255 && (in_ready !== 1'b0 || busy !== 1'b1)) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clear_sequence got bad_cycles=%0d exp=0", bad); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL clear_to_load_rdy got=%0h exp=1", in_ready); end
        in_valid = 1'b1; in_data = 4'h5; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b1, 8'd0, 4'h5}) begin
            failures++; $display("FAIL clear_load_w got we=%0h addr=%0h data=%0h exp 1/0/5", mem_write_enable, mem_write_address, mem_write_data);
        end
        checks++;
        if ({done, word_count} !== {1'b1, 9'd1}) begin failures++; $display("FAIL clear_load_status got done=%0h wc=%0d exp 1/1", done, word_count); end
        tick();
        checks++;
        if (wr_addr.size() != 257) begin failures++; $display("FAIL clear_total_writes got=%0d exp=257", wr_addr.size()); end
    endtask

    task automatic test_overflow();
        int bad;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_log();
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; in_data = 4'(i); in_last = 1'b0;
            tick();
        end
        checks++;
        if ({done, overflow, in_ready} !== 3'b110) begin
            failures++; $display("FAIL ovf_status got done/ovf/rdy=%0b exp=110", {done, overflow, in_ready});
        end
        checks++;
        if (word_count !== 9'd256) begin failures++; $display("FAIL ovf_word_count got=%0d exp=256", word_count); end
        in_data = 4'hF;
        tick();
        checks++;
        if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL ovf_extra_beat_we got=%0h exp=0", mem_write_enable); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (wr_addr.size() != 256) begin failures++; $display("FAIL ovf_write_count got=%0d exp=256", wr_addr.size()); end
        bad = 0;
        for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== 4'(i)) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL ovf_write_contents got bad=%0d exp=0", bad); end
    endtask

    task automatic test_gaps();
        int pat[5] = '{1, 0, 0, 1, 1};
        int bad;
        logic [3:0] d;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_log();
        bad = 0;
        d = 4'h1;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[i][0];
            in_data  = d;
            in_last  = 1'b0;
            tick();
            if (mem_write_enable !== pat[i][0]) bad++;
            if (pat[i] == 1) d = d + 4'h1;
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bad != 0) begin failures++; $display("FAIL gaps_we_pattern got bad=%0d exp=0", bad); end
        checks++;
        if (wr_addr.size() != 3) begin
            failures++; $display("FAIL gaps_write_count got=%0d exp=3", wr_addr.size());
        end else begin
            checks++;
            if ({wr_addr[0], wr_addr[1], wr_addr[2], wr_data[0], wr_data[1], wr_data[2]} !== {8'd0, 8'd1, 8'd2, 4'h1, 4'h2, 4'h3}) begin
                failures++; $display("FAIL gaps_contents got a=%0h,%0h,%0h d=%0h,%0h,%0h exp a=0,1,2 d=1,2,3",
                                     wr_addr[0], wr_addr[1], wr_addr[2], wr_data[0], wr_data[1], wr_data[2]);
            end
        end
        checks++;
        if ({busy, word_count} !== {1'b1, 9'd3}) begin failures++; $display("FAIL gaps_status got busy=%0h wc=%0d exp 1/3", busy, word_count); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'h6;
        tick();
        in_data = 4'h9;
        tick();
        // Beat 0x9 was accepted at the previous edge; reset now, with a beat still offered.
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, mem_write_enable, busy, done, overflow, word_count, mem_write_address, mem_write_data} !== 26'h0) begin
            failures++; $display("FAIL rst_load_outputs got rdy=%0h we=%0h busy=%0h done=%0h ovf=%0h wc=%0h addr=%0h data=%0h exp all 0",
                                 in_ready, mem_write_enable, busy, done, overflow, word_count, mem_write_address, mem_write_data);
        end
        tick();
        checks++;
        if ({mem_write_enable, busy} !== 2'b00) begin failures++; $display("FAIL rst_load_idle got we/busy=%0b exp=00", {mem_write_enable, busy}); end
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'h8; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b1, 8'd0, 4'h8}) begin
            failures++; $display("FAIL rst_load_restart got we=%0h addr=%0h data=%0h exp 1/0/8", mem_write_enable, mem_write_address, mem_write_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        start = 1'b1; clear_first = 1'b1;
        tick();
        start = 1'b0; clear_first = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({mem_write_enable, busy, mem_write_address} !== 10'h0) begin
            failures++; $display("FAIL rst_clear got we=%0h busy=%0h addr=%0h exp 0/0/0", mem_write_enable, busy, mem_write_address);
        end
        tick();
        checks++;
        if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL rst_clear_no_pending got=%0h exp=0", mem_write_enable); end
    endtask

    task automatic test_start_ignored();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'h1;
        tick();
        in_valid = 1'b0;
        start = 1'b1; clear_first = 1'b1;
        tick();
        start = 1'b0; clear_first = 1'b0;
        checks++;
        if ({busy, in_ready, mem_write_enable, word_count} !== {3'b110, 9'd1}) begin
            failures++; $display("FAIL start_in_load got busy=%0h rdy=%0h we=%0h wc=%0d exp 1/1/0/1", busy, in_ready, mem_write_enable, word_count);
        end
        in_valid = 1'b1; in_data = 4'h2; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if ({mem_write_address, mem_write_data, word_count, done} !== {8'd1, 4'h2, 9'd2, 1'b1}) begin
            failures++; $display("FAIL start_counter_kept got addr=%0h data=%0h wc=%0d done=%0h exp 1/2/2/1",
                                 mem_write_address, mem_write_data, word_count, done);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, word_count, in_ready} !== {1'b0, 9'd0, 1'b1}) begin
            failures++; $display("FAIL start_after_done got done=%0h wc=%0d rdy=%0h exp 0/0/1", done, word_count, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_plain_load();
        test_clear_load();
        test_overflow();
        test_gaps();
        test_reset_mid_load();
        test_reset_mid_clear();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter CELL_COUNT, default 256: number of memory cells loaded or cleared.
REQ-002 The block SHALL have parameter LINE_WIDTH, default 4: memory data width in bits.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 8: memory address width, with 2^ADDR_WIDTH >= CELL_COUNT.
REQ-004 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1: begin a load session, sampled only in IDLE or DONE.
REQ-007 The block SHALL have port clear_first, input, 1: sampled with start; 1 selects zero-fill of all cells before loading.
REQ-008 The block SHALL have port in_valid, input, 1: upstream data beat present.
REQ-009 The block SHALL have port in_data, input, LINE_WIDTH: upstream data beat.
REQ-010 The block SHALL have port in_last, input, 1: the current beat is the final program word.
REQ-011 The block SHALL have port in_ready, output, 1: the loader accepts a beat this cycle.
REQ-012 The block SHALL have port mem_write_address, output, ADDR_WIDTH: memory write address.
REQ-013 The block SHALL have port mem_write_data, output, LINE_WIDTH: memory write data.
REQ-014 The block SHALL have port mem_write_enable, output, 1: memory write strobe, one write per asserted cycle.
REQ-015 The block SHALL have port busy, output, 1: high in CLEAR and LOAD.
REQ-016 The block SHALL have port done, output, 1: high in DONE.
REQ-017 The block SHALL have port overflow, output, 1: the session ended because memory filled without in_last.
REQ-018 The block SHALL have port word_count, output, ADDR_WIDTH+1: number of beats accepted in the current or last session.

Function
REQ-019 The block SHALL implement the states IDLE, CLEAR, LOAD and DONE.
REQ-020 In IDLE or DONE, start=1 SHALL clear done, overflow and word_count, zero the address counter, and go to CLEAR when clear_first=1 or to LOAD otherwise.
REQ-021 start SHALL be ignored in CLEAR and LOAD.
REQ-022 In CLEAR, each cycle SHALL issue one registered write of data 0 at the address counter, then increment the counter.
REQ-023 CLEAR SHALL write cells 0..CELL_COUNT-1, which takes exactly CELL_COUNT cycles, then go to LOAD with the counter at 0.
REQ-024 in_ready SHALL be 1 only in LOAD, as a registered function of state.
REQ-025 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-026 For a beat accepted in cycle N, cycle N+1 SHALL drive mem_write_enable=1, mem_write_address = the counter value at N, and mem_write_data = in_data at N.
REQ-027 Each accepted beat SHALL increment the counter and word_count by 1.
REQ-028 In LOAD with in_valid=0, the outputs SHALL drive mem_write_enable=0 on the following cycle; gaps between beats are permitted.
REQ-029 An accepted beat with in_last=1 SHALL be written and SHALL move the block to DONE, with in_ready=0 from the next cycle.
REQ-030 An accepted beat at counter CELL_COUNT-1 with in_last=0 SHALL be written, SHALL set overflow=1 and SHALL move the block to DONE.
REQ-031 An accepted beat at counter CELL_COUNT-1 with in_last=1 SHALL move the block to DONE with overflow=0.
REQ-032 The address counter SHALL never wrap.
REQ-033 In DONE, done=1 and word_count SHALL hold until the next start or reset.
REQ-034 mem_write_enable SHALL be 0 in IDLE and DONE, apart from the single trailing write cycle that follows the final accepted beat.
REQ-035 mem_write_address and mem_write_data SHALL hold their last values whenever mem_write_enable=0.

Reset
REQ-036 When reset=1 at a clock edge, the block SHALL go to IDLE and drive in_ready, mem_write_enable, busy, done and overflow to 0 and word_count, mem_write_address, mem_write_data and the counter to 0.
REQ-037 Reset SHALL take priority over start and over handshakes in the same cycle.
REQ-038 After reset, no pending write SHALL be issued, including when reset arrives mid-CLEAR or mid-LOAD.

Verification
REQ-039 Scenario, plain load: start with clear_first=0, beats 0x3, 0x7, 0xA, the last with in_last -> writes at addr 0,1,2, each one cycle after acceptance; done=1, word_count=3, overflow=0.
REQ-040 Scenario, clear then load: start with clear_first=1 -> busy=1, 256 consecutive writes of 0 to addr 0..255, then in_ready=1; one beat 0x5 with in_last -> write of 0x5 at addr 0, word_count=1.
REQ-041 Scenario, overflow: 256 beats, none with in_last -> 256 writes, in_ready=0 afterwards, done=1, overflow=1, word_count=256; a 257th in_valid receives no write.
REQ-042 Scenario, backpressure and gaps: in_valid toggled 1,0,0,1,1 in LOAD -> exactly 3 writes at consecutive addresses 0,1,2 with no duplicates.
REQ-043 Scenario, reset mid-LOAD: reset asserted in the cycle after a beat is accepted -> mem_write_enable=0 and all outputs 0 the next cycle; start then restarts at addr 0.
REQ-044 Scenario, start ignored: a start pulse in LOAD -> no change to the counter or word_count; after DONE, start clears done and word_count.
